// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with carry/borrow wrap pulses and a
// time-multiplexed digit scan for a shared seven-segment decoder.
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                inc,
    input  logic                dec,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic [3:0]          bcd,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                carry,
    output logic                borrow
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(DIGITS - 1);

    logic [DIGITS-1:0][3:0] count_q, count_d;
    logic                   carry_q, carry_d;
    logic                   borrow_q, borrow_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SW-1:0]          scan_q, scan_d;
    logic                   all_nine, all_zero, ripple;

    // Decimal ripple: a digit wraps and passes the carry/borrow on only
    // while every lower digit has also wrapped in this same cycle.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        ripple   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[i] != 4'd9) all_nine = 1'b0;
            if (count_q[i] != 4'd0) all_zero = 1'b0;
        end
        if (clear) begin
            count_d = '0;
        end else if (inc && !dec) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    if (count_q[i] >= 4'd9) begin
                        count_d[i] = 4'd0;
                    end else begin
                        count_d[i] = count_q[i] + 4'd1;
                        ripple     = 1'b0;
                    end
                end
            end
            carry_d = all_nine;
        end else if (dec && !inc) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    if (count_q[i] == 4'd0) begin
                        count_d[i] = 4'd9;
                    end else begin
                        count_d[i] = count_q[i] - 4'd1;
                        ripple     = 1'b0;
                    end
                end
            end
            borrow_d = all_zero;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        scan_d  = scan_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            presc_q  <= '0;
            scan_q   <= '0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            presc_q  <= presc_d;
            scan_q   <= scan_d;
        end
    end

    // Digit mux is driven straight from registers so a count update shows
    // on bcd in the same cycle it shows on count_bcd.
    always_comb begin
        bcd       = 4'd0;
        digit_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_q == SW'(i)) begin
                bcd          = count_q[i];
                digit_sel[i] = 1'b1;
            end
        end
    end

    assign count_bcd = count_q;
    assign carry     = carry_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: decimal-integer reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_bcd_scan_counter;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int MOD      = 10000;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear   = 1'b0;
    logic        inc     = 1'b0;
    logic        dec     = 1'b0;
    logic [15:0] count_bcd;
    logic [3:0]  bcd;
    logic [3:0]  digit_sel;
    logic        carry;
    logic        borrow;

    int vectors     = 0;
    int miscompares = 0;
    logic mon_en    = 1'b0;

    int   m_count  = 0;
    int   m_ticks  = 0;
    logic m_carry  = 1'b0;
    logic m_borrow = 1'b0;
    int   carry_total  = 0;
    int   borrow_total = 0;

    bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .inc       (inc),
        .dec       (dec),
        .count_bcd (count_bcd),
        .bcd       (bcd),
        .digit_sel (digit_sel),
        .carry     (carry),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int idx);
        int x;
        x = v;
        for (int i = 0; i < idx; i++) x = x / 10;
        return x % 10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count as a plain integer modulo 10^DIGITS, scan
    // position derived from the number of edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_count  <= 0;
            m_ticks  <= 0;
            m_carry  <= 1'b0;
            m_borrow <= 1'b0;
        end else begin
            m_carry  <= 1'b0;
            m_borrow <= 1'b0;
            if (clear) begin
                m_count <= 0;
            end else if (inc && !dec) begin
                m_count <= (m_count + 1) % MOD;
                m_carry <= (m_count == MOD - 1);
            end else if (dec && !inc) begin
                m_count  <= (m_count + MOD - 1) % MOD;
                m_borrow <= (m_count == 0);
            end
            m_ticks <= m_ticks + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            int scan;
            scan = (m_ticks / SCAN_DIV) % DIGITS;
            chk("cyc_count_bcd", 32'(count_bcd), 32'(to_bcd(m_count)));
            chk("cyc_bcd", 32'(bcd), 32'(digit_of(m_count, scan)));
            chk("cyc_digit_sel", 32'(digit_sel), 32'(1 << scan));
            chk("cyc_carry", 32'(carry), 32'(m_carry));
            chk("cyc_borrow", 32'(borrow), 32'(m_borrow));
            chk("cyc_not_both", 32'(carry & borrow), 32'd0);
            for (int i = 0; i < DIGITS; i++)
                chk("cyc_digit_le9", 32'(count_bcd[4*i +: 4] > 4'd9), 32'd0);
            if (carry) carry_total++;
            if (borrow) borrow_total++;
        end
    end

    task automatic step(input logic i_inc, input logic i_dec, input logic i_clr);
        inc   = i_inc;
        dec   = i_dec;
        clear = i_clr;
        @(posedge clk);
        #1;
        inc   = 1'b0;
        dec   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_count"}, 32'(count_bcd), 32'h0);
        chk({tag, "_bcd"}, 32'(bcd), 32'h0);
        chk({tag, "_sel"}, 32'(digit_sel), 32'h1);
        chk({tag, "_carry"}, 32'(carry), 32'h0);
        chk({tag, "_borrow"}, 32'(borrow), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b0;
        logic [3:0] prev_sel;
        logic       aligned;
        logic [3:0] exp_bcd_tab [5];
        exp_bcd_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        #1;
        chk_reset_values("init");

        // Requests while in reset are ignored
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("reset_ignores_inc", 32'(count_bcd), 32'h0);
        reset_n = 1'b1;

        // First prescaler wrap exactly SCAN_DIV edges after release
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("first_wrap_not_early", 32'(digit_sel), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("first_wrap_on_time", 32'(digit_sel), 32'h2);

        // 12 single-cycle inc pulses
        c0 = carry_total;
        step(1'b0, 1'b0, 1'b1);
        repeat (12) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("inc12_count", 32'(count_bcd), 32'h0012);
        chk("inc12_no_carry", 32'(carry_total - c0), 32'd0);

        // Wrap both ways
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("dec_from0_count", 32'(count_bcd), 32'h9999);
        chk("dec_from0_borrow", 32'(borrow), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("borrow_one_cycle", 32'(borrow), 32'h0);
        c0 = carry_total;
        b0 = borrow_total;
        step(1'b1, 1'b0, 1'b0);
        chk("wrap_up_count", 32'(count_bcd), 32'h0000);
        chk("wrap_up_carry", 32'(carry), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("carry_one_cycle", 32'(carry), 32'h0);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_down_count", 32'(count_bcd), 32'h9999);
        chk("wrap_down_borrow", 32'(borrow), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_down_hold", 32'(count_bcd), 32'h9999);
        chk("wrap_pulses", 32'((carry_total - c0) * 16 + (borrow_total - b0)), 32'h11);

        // Borrow through a zero digit, inc+dec hold, clear priority
        step(1'b0, 1'b0, 1'b1);
        repeat (190) step(1'b1, 1'b0, 1'b0);
        chk("load_0190", 32'(count_bcd), 32'h0190);
        step(1'b0, 1'b1, 1'b0);
        chk("dec_0189", 32'(count_bcd), 32'h0189);
        step(1'b1, 1'b1, 1'b0);
        chk("inc_dec_hold", 32'(count_bcd), 32'h0189);
        step(1'b1, 1'b0, 1'b1);
        chk("clear_priority", 32'(count_bcd), 32'h0000);
        chk("clear_no_carry", 32'(carry), 32'h0);

        // Scan sequence with count 4321
        repeat (4321) step(1'b1, 1'b0, 1'b0);
        chk("load_4321", 32'(count_bcd), 32'h4321);
        aligned  = 1'b0;
        prev_sel = digit_sel;
        for (int n = 0; n < 40 && !aligned; n++) begin
            step(1'b0, 1'b0, 1'b0);
            if (prev_sel == 4'b1000 && digit_sel == 4'b0001) aligned = 1'b1;
            prev_sel = digit_sel;
        end
        chk("scan_align_timeout", 32'(aligned), 32'h1);
        for (int k = 0; k < 20; k++) begin
            if (k != 0) step(1'b0, 1'b0, 1'b0);
            chk("scan_sel", 32'(digit_sel), 32'(4'b0001 << ((k / 4) % 4)));
            chk("scan_bcd", 32'(bcd), 32'(exp_bcd_tab[k / 4]));
        end

        // Asynchronous reset mid-count, scan index 2
        step(1'b0, 1'b0, 1'b1);
        repeat (57) step(1'b1, 1'b0, 1'b0);
        aligned = 1'b0;
        for (int n = 0; n < 20 && !aligned; n++) begin
            if (((m_ticks / SCAN_DIV) % DIGITS) == 2) aligned = 1'b1;
            else step(1'b0, 1'b0, 1'b0);
        end
        chk("pre_reset_count", 32'(count_bcd), 32'h0057);
        chk("pre_reset_sel", 32'(digit_sel), 32'h4);
        chk("pre_reset_bcd", 32'(bcd), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        step(1'b1, 1'b0, 1'b1);
        chk_reset_values("held_rst");
        reset_n = 1'b1;

        // Long increment run: exactly one carry
        c0 = carry_total;
        repeat (10000) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("long_run_carries", 32'(carry_total - c0), 32'd1);
        chk("long_run_count", 32'(count_bcd), 32'h0000);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits counted and scanned (legal range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, giving the clk cycles each digit is displayed per scan step (legal range >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port clear, input, 1, synchronous clear of the count value.
REQ-006 SHALL have port inc, input, 1, count-up request sampled each clk edge.
REQ-007 SHALL have port dec, input, 1, count-down request sampled each clk edge.
REQ-008 SHALL have port count_bcd, output, 4*DIGITS, packed count value; digit 0 (least significant) in bits [3:0].
REQ-009 SHALL have port bcd, output, 4, the digit currently selected by the scan, for the downstream seven-segment coder.
REQ-010 SHALL have port digit_sel, output, DIGITS, one-hot active-high select of the digit currently driven on bcd.
REQ-011 SHALL have port carry, output, 1, one-cycle pulse on up-count wrap from all-9s to all-0s.
REQ-012 SHALL have port borrow, output, 1, one-cycle pulse on down-count wrap from all-0s to all-9s.

Function
REQ-013 SHALL hold each count digit in the range 0..9 at all times.
REQ-014 SHALL, on a clk edge with inc=1 and dec=0, add 1 to the count in decimal: a digit at 9 becomes 0 and carries to the next digit in the same cycle; the result is visible on count_bcd after that edge (latency 1).
REQ-015 SHALL, on a clk edge with dec=1 and inc=0, subtract 1 in decimal: a digit at 0 becomes 9 and borrows from the next digit in the same cycle; latency 1.
REQ-016 SHALL leave the count unchanged when inc=1 and dec=1 together, or when both are 0.
REQ-017 SHALL give clear priority over inc and dec: on a clk edge with clear=1, the count becomes 0 and carry and borrow are 0.
REQ-018 SHALL set carry=1 for exactly the one cycle after an increment from all-9s; the count wraps to all-0s.
REQ-019 SHALL set borrow=1 for exactly the one cycle after a decrement from all-0s; the count wraps to all-9s.
REQ-020 SHALL drive carry and borrow as 0 in every other cycle, and never both 1 at once.
REQ-021 SHALL run a free-running prescaler counting 0..SCAN_DIV-1, then wrapping to 0; it is unaffected by clear, inc and dec.
REQ-022 SHALL advance the scan index by one on the clk edge where the prescaler wraps, with scan index sequence 0,1,...,DIGITS-1,0.
REQ-023 SHALL drive bcd as the count digit at the scan index, and digit_sel with only bit [scan index] set; both change only after a clk edge.
REQ-024 SHALL reflect a count update on bcd in the same cycle it appears on count_bcd, when the updated digit is the one selected.
REQ-025 SHALL, with DIGITS=1, hold digit_sel=1 permanently while the prescaler still runs.

Reset
REQ-026 SHALL, while reset_n=0 and independent of clk, force count_bcd=0, bcd=0, digit_sel=1 (digit 0), carry=0, borrow=0, prescaler=0 and scan index=0.
REQ-027 SHALL, when reset is asserted mid-count or mid-scan, discard all state; after release, the first prescaler wrap occurs SCAN_DIV edges later.
REQ-028 SHALL ignore inc, dec and clear while reset_n=0.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-029 SHALL verify: count 0 with 12 single-cycle inc pulses -> count_bcd=16'h0012; no carry.
REQ-030 SHALL verify: count 16'h9999, inc for 1 cycle -> count_bcd=16'h0000 and carry=1 for exactly 1 cycle; then dec for 1 cycle -> 16'h9999 and borrow=1 for 1 cycle.
REQ-031 SHALL verify: count 16'h0190, dec -> 16'h0189; inc and dec together -> unchanged; clear with inc -> 16'h0000.
REQ-032 SHALL verify: count 16'h4321, no inc/dec, after reset release -> digit_sel steps 0001,0010,0100,1000,0001, each held 4 cycles, with bcd 1,2,3,4,1 respectively.
REQ-033 SHALL verify: reset_n asserted asynchronously between edges at count 16'h0057, scan index 2 -> outputs go to reset values immediately, without waiting for a clk edge.
REQ-034 SHALL verify: inc every cycle for 10000 cycles from 0 -> exactly one carry pulse, count back to 16'h0000, and every digit stays <= 9 throughout.
